// File: rtl/conv_output_stage_if.sv
// Bundles the pixel input strobe and data, the output FIFO handshake and the status signals of conv_output_stage.
// Handshake: the head entry moves only in a cycle where out_valid and out_ready are both high.
// out_data and out_last are stable and meaningful whenever out_valid is high.
// out_ready may change freely while out_valid is low.
interface conv_output_stage_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             in_valid;
  logic [31:0]      conv_in;
  logic [7:0]       out_data;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;

  // The design side of the bus.
  modport slave (
    input  in_valid, conv_in, out_ready,
    output out_data, out_last, out_valid, overflow, fifo_count
  );

  // The producer and consumer side, as used by a testbench or by neighbouring blocks.
  modport master (
    output in_valid, conv_in, out_ready,
    input  out_data, out_last, out_valid, overflow, fifo_count
  );
endinterface

// File: rtl/conv_output_stage.sv
// The output stage of the convolution layer.
// Delays the upstream pixel strobe to line up with the adder-tree result.
// Tracks the image position of each result and drops results whose window overlaps the border.
// Requantizes the kept results to unsigned 8 bits with rounding and saturation.
// Buffers the results in a show-ahead FIFO.
module conv_output_stage #(
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8,
  parameter int KERNEL_W     = 3,
  parameter int KERNEL_H     = 3,
  parameter int PIPE_LATENCY = 4,
  parameter int SHIFT        = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input logic clock,
  input logic reset,
  conv_output_stage_if.slave bus
);
  localparam int CW    = $clog2(IMG_WIDTH + 1);
  localparam int RW    = $clog2(IMG_HEIGHT + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // The rounding constant is half an LSB of the shifted result, or zero when there is no shift.
  localparam logic signed [33:0] RND =
    (SHIFT == 0) ? 34'sd0 : (34'sd1 <<< ((SHIFT == 0) ? 0 : (SHIFT - 1)));

  // ---------------- strobe delay line ----------------
  logic [PIPE_LATENCY-1:0] tap_q, tap_d;
  logic                    tap_valid;

  // Shift the strobe one stage per cycle. The last stage coincides with the result on conv_in.
  always_comb begin
    tap_d    = tap_q;
    tap_d[0] = bus.in_valid;
    for (int i = 1; i < PIPE_LATENCY; i++) tap_d[i] = tap_q[i-1];
  end

  assign tap_valid = tap_q[PIPE_LATENCY-1];

  // ---------------- position tracking ----------------
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          keep, last;

  // Advance the column on every aligned result. Wrap it into the row counter, and wrap the row counter at the end of the frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (tap_valid) begin
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_HEIGHT - 1)) row_d = '0;
        else                              row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign keep = tap_valid && (col_q >= CW'(KERNEL_W - 1)) && (row_q >= RW'(KERNEL_H - 1));
  assign last = keep && (col_q == CW'(IMG_WIDTH - 1)) && (row_q == RW'(IMG_HEIGHT - 1));

  // ---------------- requantization ----------------
  logic signed [33:0] ext, sum, shr;
  logic [7:0]         q8;

  // Use 34-bit arithmetic so that adding the rounding constant to the most positive input cannot wrap.
  always_comb begin
    ext = {{2{bus.conv_in[31]}}, bus.conv_in};
    sum = ext + RND;
    shr = sum >>> SHIFT;
    if (shr[33])               q8 = 8'd0;
    else if (shr > 34'sd255)   q8 = 8'd255;
    else                       q8 = shr[7:0];
  end

  // ---------------- result register ----------------
  logic [7:0] data_q;
  logic       last_q, keep_q;

  // Register one result per cycle. The keep flag in this register is the FIFO write request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      last_q <= 1'b0;
      keep_q <= 1'b0;
      tap_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      tap_q  <= tap_d;
      col_q  <= col_d;
      row_q  <= row_d;
      keep_q <= keep;
      last_q <= last;
      if (keep) data_q <= q8;
    end
  end

  // ---------------- output FIFO ----------------
  logic [8:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             empty, full, rd, wr, drop;
  logic [8:0]       head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign rd    = !empty && bus.out_ready;
  // A write into a full FIFO still fits when the head leaves in the same cycle.
  assign wr    = keep_q && (!full || rd);
  assign drop  = keep_q && full && !rd;

  // Store the entries. The storage array needs no reset because the occupancy count qualifies every read.
  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr_q] <= {last_q, data_q};
  end

  // Update the pointers, the occupancy count and the sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr && !rd)      count_q <= count_q + 1'b1;
      else if (!wr && rd) count_q <= count_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign head           = mem[rd_ptr_q];
  assign bus.out_valid  = !empty;
  assign bus.out_data   = empty ? 8'd0 : head[7:0];
  assign bus.out_last   = empty ? 1'b0 : head[8];
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;
endmodule

// File: doc/conv_output_stage.md
Name: conv_output_stage

Overview:
Receiving end of the convolution layer's 32-bit `pixel_out` stream. Aligns the upstream pixel strobe with the mult-adder tree latency and tracks the image position of each result. It discards partial-window (border) results and requantizes the valid ones to unsigned 8-bit with rounding and saturation. Results are buffered in a FIFO with a valid/ready handshake, so the next layer's 8-bit `pixel_in` can be fed from it.

Parameters:
- IMG_WIDTH, 8, input image width in pixels (≥ KERNEL_W)
- IMG_HEIGHT, 8, input image height in pixels (≥ KERNEL_H)
- KERNEL_W, 3, window x dimension (shift-register parallel depth)
- KERNEL_H, 3, window y dimension (number of shift-register rows)
- PIPE_LATENCY, 4, cycles from an upstream pixel shift to its result on `conv_in` (≥ 1)
- SHIFT, 8, requantization right shift (0..31)
- FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥ 2)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  high in the cycle the upstream shift register accepts a pixel
- conv_in  in  32  signed two's-complement convolution result
- out_data  out  8  requantized pixel at FIFO head
- out_last  out  1  head entry is the final kept pixel of a frame
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- overflow  out  1  sticky: a kept result was dropped because the FIFO was full
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Reset is asynchronous and active-high; all state clears immediately. Cleared state:
  - delay line, col/row counters, requant register
  - FIFO pointers
  - outputs `out_data`, `out_last`, `out_valid`, `overflow` = 0; `fifo_count` = 0
- Delay line: `in_valid` passes through a PIPE_LATENCY-stage shift register, producing `tap_valid`. `conv_in` is sampled only in cycles where `tap_valid` = 1.
- Position counters `col`/`row` start at 0 and advance once per `tap_valid`:
  - `col` wraps IMG_WIDTH-1 → 0 and increments `row`
  - `row` wraps IMG_HEIGHT-1 → 0, which ends the frame
- keep = `tap_valid` & (`col` ≥ KERNEL_W-1) & (`row` ≥ KERNEL_H-1).
- last = keep & (`col` == IMG_WIDTH-1) & (`row` == IMG_HEIGHT-1).
- Requantization, in 34-bit signed arithmetic so no intermediate overflow:
  - SHIFT > 0: r = (conv_in + 2^(SHIFT-1)) >>> SHIFT (round half up)
  - SHIFT = 0: r = conv_in
  - r < 0 → 0; r > 255 → 255; otherwise r[7:0]
- Pipeline:
  - cycle T: keep asserted; data, last and keep registered at edge T+1
  - edge T+2: FIFO write
  - first `out_valid` with FIFO previously empty: cycle T+2
- FIFO: 9-bit entries {last, data}. `out_data` and `out_last` are the head entry (show-ahead), valid whenever `out_valid` = 1.
- Read occurs when `out_valid` & `out_ready`; `out_ready` is ignored while empty.
- Write when full:
  - with a read in the same cycle: write accepted, count unchanged, no overflow
  - with no read: entry dropped, `overflow` set and held until reset
- Read and write in the same cycle while empty: the write lands and `out_valid` rises the next cycle; no bypass.
- Gaps in `in_valid` are allowed; counters and outputs depend only on the number of strobes, not their timing.
- Reset mid-frame: the partial frame is discarded; the first post-reset `tap_valid` is position (0,0).

Test Plan:
- Crop: defaults, 64 consecutive `in_valid` with `conv_in` = 256·k (k = strobe index 0..63) → exactly 36 outputs. First output data = 18 (k = 18); last output data = 63 with `out_last` = 1 (k = 63); `out_last` = 0 on the other 35.
- Rounding/saturation, SHIFT = 8, KERNEL 1×1: `conv_in` → `out_data`:
  - 384 → 2
  - 383 → 1
  - -1000 → 0
  - 65536 → 255
  - 0x7FFFFFFF → 255
  - 127 → 0; 128 → 1
- Latency: single keep at cycle T with FIFO empty and `out_ready` = 1 → `out_valid` high exactly in cycle T+2, low at T+3.
- Backpressure: `out_ready` = 0 for a full frame → `fifo_count` = 16 and `overflow` = 1 after the 17th kept result. Then `out_ready` = 1 → 16 consecutive outputs; `fifo_count` returns to 0. A later full-while-reading write keeps count at 16, and `overflow` stays 1 (sticky).
- Gapped input: `in_valid` every other cycle for 64 strobes → same 36 values as the Crop case; `overflow` = 0.
- Reset mid-frame: reset for 2 cycles after 30 strobes → all outputs 0 immediately. A following full frame yields exactly 36 outputs matching the Crop case.
